// File: rtl/demux1x2_stream.sv
// demux1x2_stream: routes one valid/ready stream to y0 or y1 by in_sel, each output with its own one-deep register.
// Latency 1 cycle; a word accepted at an edge is on yk_valid/yk_data right after it, one word per clock per output.
// Backpressure: in_ready drops only when the selected output is FULL and stalled. Optional counters: DEMUX1X2_CNT_EN.
module demux1x2_stream #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [WIDTH-1:0] y1_data
`ifdef DEMUX1X2_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
`endif
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       st0, st1;
  logic [WIDTH-1:0] dat0, dat1;
  logic             sel_empty, sel_ready;
  logic             acc, a0, a1, dr0, dr1;

  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
    $error("demux1x2_stream: WIDTH and CNT_WIDTH must be at least 1");
  end

  // Only the selected channel gates the producer, so a stalled channel never blocks the other.
  always_comb begin
    sel_empty = 1'b0;
    sel_ready = 1'b0;
    if (in_sel) begin
      sel_empty = (st1 == EMPTY);
      sel_ready = y1_ready;
    end else begin
      sel_empty = (st0 == EMPTY);
      sel_ready = y0_ready;
    end
  end

  assign in_ready = sel_empty | sel_ready;
  assign acc      = in_valid & in_ready;
  assign a0       = acc & ~in_sel;
  assign a1       = acc &  in_sel;

  assign y0_valid = (st0 == FULL);
  assign y1_valid = (st1 == FULL);
  assign y0_data  = dat0;
  assign y1_data  = dat1;
  assign dr0      = y0_valid & y0_ready;
  assign dr1      = y1_valid & y1_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st0  <= EMPTY;
      dat0 <= '0;
    end else begin
      case (st0)
        EMPTY: begin
          if (a0) begin
            st0  <= FULL;
            dat0 <= in_data;
          end
        end
        FULL: begin
          // Drain and reload in the same edge keeps the channel FULL with no bubble.
          if (dr0) begin
            if (a0) dat0 <= in_data;
            else    st0  <= EMPTY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st1  <= EMPTY;
      dat1 <= '0;
    end else begin
      case (st1)
        EMPTY: begin
          if (a1) begin
            st1  <= FULL;
            dat1 <= in_data;
          end
        end
        FULL: begin
          if (dr1) begin
            if (a1) dat1 <= in_data;
            else    st1  <= EMPTY;
          end
        end
      endcase
    end
  end

`ifdef DEMUX1X2_CNT_EN
  // Free-running delivery counters; wrap silently.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (dr0) cnt0 <= cnt0 + 1'b1;
      if (dr1) cnt1 <= cnt1 + 1'b1;
    end
  end
`else
  // Counters not built; CNT_WIDTH is kept so parameter overrides stay valid.
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// Bench for demux1x2_stream: queue model compared every cycle plus directed literal scenarios.
module tb_demux1x2_stream;
  localparam int W  = 32;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         clrn = 1'b0;
  logic         in_valid, in_ready, in_sel;
  logic [W-1:0] in_data;
  logic         y0_valid, y0_ready, y1_valid, y1_ready;
  logic [W-1:0] y0_data, y1_data;
`ifdef DEMUX1X2_CNT_EN
  logic [CW-1:0] cnt0, cnt1;
`endif

  demux1x2_stream #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .clrn(clrn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_data(y0_data),
    .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_data(y1_data)
`ifdef DEMUX1X2_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: each channel is a queue of held words (at most one), plus the last word loaded.
  logic [W-1:0] q0[$], q1[$];
  logic [W-1:0] last0 = '0, last1 = '0;
  int           n0 = 0, n1 = 0;
  logic         p_push0 = 0, p_push1 = 0, p_pop0 = 0, p_pop1 = 0, p_dr0 = 0, p_dr1 = 0;
  logic [W-1:0] p_dat = '0, p_y0 = '0, p_y1 = '0;
  logic         exp_rdy;
  logic [W-1:0] log0[$], log1[$];
  logic [W-1:0] exp_q[$];

  task automatic clear_pending();
    p_push0 = 0; p_push1 = 0; p_pop0 = 0; p_pop1 = 0; p_dr0 = 0; p_dr1 = 0;
  endtask

  always @(negedge clrn) begin
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0; n0 = 0; n1 = 0;
    clear_pending();
  end

  always @(negedge clk) begin
    if (!clrn) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_y0_valid", y0_valid, 0);
      check("rst_y1_valid", y1_valid, 0);
      check("rst_y0_data", y0_data, 0);
      check("rst_y1_data", y1_data, 0);
      clear_pending();
    end else begin
      exp_rdy = in_sel ? (q1.size() == 0 || y1_ready) : (q0.size() == 0 || y0_ready);
      check("cyc_in_ready", in_ready, exp_rdy);
      check("cyc_y0_valid", y0_valid, q0.size() != 0);
      check("cyc_y1_valid", y1_valid, q1.size() != 0);
      check("cyc_y0_data", y0_data, last0);
      check("cyc_y1_data", y1_data, last1);
`ifdef DEMUX1X2_CNT_EN
      check("cyc_cnt0", cnt0, n0 % (1 << CW));
      check("cyc_cnt1", cnt1, n1 % (1 << CW));
`endif
      p_push0 = in_valid && exp_rdy && !in_sel;
      p_push1 = in_valid && exp_rdy && in_sel;
      p_dat   = in_data;
      p_pop0  = (q0.size() != 0) && y0_ready;
      p_pop1  = (q1.size() != 0) && y1_ready;
      p_dr0   = y0_valid && y0_ready;
      p_dr1   = y1_valid && y1_ready;
      p_y0    = y0_data;
      p_y1    = y1_data;
    end
  end

  always @(posedge clk) begin
    if (clrn) begin
      if (p_pop0) begin void'(q0.pop_front()); n0++; end
      if (p_pop1) begin void'(q1.pop_front()); n1++; end
      if (p_push0) begin q0.push_back(p_dat); last0 = p_dat; end
      if (p_push1) begin q1.push_back(p_dat); last1 = p_dat; end
      if (p_dr0) log0.push_back(p_y0);
      if (p_dr1) log1.push_back(p_y1);
    end
    clear_pending();
  end

  task automatic check_seq(input string name, input logic [W-1:0] got[$], input logic [W-1:0] exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(name, got[i], exp[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; in_sel = 0; in_data = '0; y0_ready = 0; y1_ready = 0;
    #1;
    check("init_in_ready", in_ready, 1);
    check("init_y0_valid", y0_valid, 0);
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;

    // Reset mid-operation
    y0_ready = 0; y1_ready = 1;
    drive(0, 32'hA5A5_A5A5);
    tick();
    in_valid = 0;
    tick();
    check("s1_loaded_valid", y0_valid, 1);
    check("s1_loaded_data", y0_data, 32'hA5A5_A5A5);
    #2 clrn = 1'b0;
    #1;
    check("s1_rst_valid", y0_valid, 0);
    check("s1_rst_data", y0_data, 0);
    check("s1_rst_in_ready", in_ready, 1);
    #3 clrn = 1'b1;
    tick(); tick();
    check("s1_after_valid", y0_valid, 0);

    // Alternating select at full rate
    log0.delete(); log1.delete();
    y0_ready = 1; y1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(i[0], W'(i + 1));
      #1 check("s2_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 0;
    tick(); tick();
    exp_q = {32'd1, 32'd3}; check_seq("s2_y0_seq", log0, exp_q);
    exp_q = {32'd2, 32'd4}; check_seq("s2_y1_seq", log1, exp_q);

    // Stall isolation
    log0.delete(); log1.delete();
    y0_ready = 0; y1_ready = 1;
    drive(0, 32'h11);
    tick();
    drive(0, 32'h22);
    #1 check("s3_stalled_rdy", in_ready, 0);
    in_sel = 1; in_data = 32'h33;
    #1 check("s3_other_free", in_ready, 1);
    in_sel = 0; in_data = 32'h22;
    tick();
    check("s3_hold_data", y0_data, 32'h11);
    y0_ready = 1;
    #1 check("s3_drain_rdy", in_ready, 1);
    tick();
    drive(1, 32'h33);
    tick();
    in_valid = 0;
    tick(); tick();
    exp_q = {32'h11, 32'h22}; check_seq("s3_y0_seq", log0, exp_q);
    exp_q = {32'h33};         check_seq("s3_y1_seq", log1, exp_q);

    // Drain and load in the same cycle
    log1.delete();
    y1_ready = 0;
    drive(1, 32'h7);
    tick();
    in_valid = 0;
    tick();
    check("s4_full_data", y1_data, 32'h7);
    y1_ready = 1;
    drive(1, 32'h8);
    #1 check("s4_in_ready", in_ready, 1);
    tick();
    check("s4_nobubble_valid", y1_valid, 1);
    check("s4_nobubble_data", y1_data, 32'h8);
    in_valid = 0;
    tick();
    check("s4_drained", y1_valid, 0);
    exp_q = {32'h7, 32'h8}; check_seq("s4_y1_seq", log1, exp_q);

    // Data stability under backpressure
    log0.delete();
    y0_ready = 0;
    drive(0, 32'hDEAD);
    tick();
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      in_sel  = 1'($urandom_range(0, 1));
      #1;
      check("s5_valid", y0_valid, 1);
      check("s5_data", y0_data, 32'hDEAD);
      tick();
    end
    y0_ready = 1;
    tick(); tick();
    exp_q = {32'hDEAD}; check_seq("s5_y0_seq", log0, exp_q);

`ifdef DEMUX1X2_CNT_EN
    // Counter wrap with 4-bit counters
    #1 clrn = 1'b0;
    #1 clrn = 1'b1;
    y0_ready = 1; y1_ready = 1;
    for (int i = 0; i < 17; i++) begin drive(1, W'(100 + i)); tick(); end
    for (int i = 0; i < 3; i++)  begin drive(0, W'(200 + i)); tick(); end
    in_valid = 0;
    tick(); tick();
    check("s6_cnt1_wrap", cnt1, 1);
    check("s6_cnt0", cnt0, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
